// File: rtl/uart_frame_tx.sv
// Drains one FRAME_LEN-byte frame from a synchronous-read byte buffer and
// serializes it 8N1, LSB first. Every output is registered.
module uart_frame_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FRAME_LEN    = 517,
  parameter int AW           = 10
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic          o_rd_en,
  output logic [AW-1:0] o_rd_addr,
  input  logic [7:0]    i_rd_data,
  output logic          o_tx,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-1:0] o_byte_cnt,
  output logic [2:0]    o_state
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW-1:0] LAST_BYTE = AW'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_busy;
  logic          r_done;
  logic          r_rd_en;
  logic [AW-1:0] r_rd_addr;
  logic [AW-1:0] r_byte_cnt;
  logic          w_baud_end;

  assign w_baud_end = (r_baud == BAUD_LAST);

  // tx is updated on the same edge that enters each state, so the line
  // changes exactly when the state does and never glitches.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_byte_cnt <= '0;
    end else begin
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (i_start) begin
            r_state    <= S_FETCH;
            r_busy     <= 1'b1;
            r_byte_cnt <= '0;
            r_rd_en    <= 1'b1;
            r_rd_addr  <= '0;
          end
        end
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          r_shift <= i_rd_data;
          r_state <= S_START;
          r_tx    <= 1'b0;
          r_baud  <= '0;
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_tx <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_byte_cnt == LAST_BYTE) begin
              r_state    <= S_IDLE;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_byte_cnt <= '0;
            end else begin
              r_state    <= S_FETCH;
              r_byte_cnt <= r_byte_cnt + 1'b1;
              r_rd_en    <= 1'b1;
              r_rd_addr  <= r_byte_cnt + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx       = r_tx;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_rd_en    = r_rd_en;
  assign o_rd_addr  = r_rd_addr;
  assign o_byte_cnt = r_byte_cnt;
  assign o_state    = r_state;

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Transmit-side counterpart of the 517-byte frame buffer: drains one complete frame from a synchronous-read byte buffer and serializes it onto a UART line, 8N1, LSB first.
- Frame layout is 1 command byte, 512 payload bytes and 4 trailer bytes, held at buffer addresses 0..FRAME_LEN-1.
- Sits between the frame buffer read port and the board UART TX pin. Started by the controller once the buffer reports a full frame.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- FRAME_LEN, 517, bytes per frame; legal range 1..1023.
- AW, 10, buffer address width; must satisfy 2^AW >= FRAME_LEN.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to send one frame; sampled only in IDLE.
- rd_en  output  1  buffer read strobe, one cycle per byte.
- rd_addr  output  AW  buffer read address; valid while rd_en=1.
- rd_data  input  8  buffer read data; valid exactly 1 cycle after the rd_en cycle.
- tx  output  1  UART serial out; idles high.
- busy  output  1  high from the cycle after start is accepted until the frame's final stop bit ends.
- done  output  1  one-cycle pulse in the cycle after the final stop bit completes.
- byte_cnt  output  AW  index of the byte currently being sent.

Behaviour:
- Reset (rst=1 at a clk edge): next-cycle values are tx=1, busy=0, done=0, rd_en=0, rd_addr=0, byte_cnt=0; state=IDLE; bit and baud counters cleared.
- Reset mid-frame aborts at once. No partial byte is completed. tx returns high on the next edge.
- FSM states: IDLE, FETCH, LOAD, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If start=1, go to FETCH, set busy=1, byte_cnt=0.
  - start while busy is ignored. It is not queued.
- FETCH (1 cycle): rd_en=1, rd_addr=byte_cnt, then go to LOAD.
- LOAD (1 cycle): latch rd_data into an 8-bit shift register, then go to START.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - Drive shift_reg[0] for CLKS_PER_BIT cycles, then shift right.
  - After 8 bits go to STOP.
  - The bit counter is 3 bits wide and its wrap from 7 to 0 ends DATA.
- STOP: tx=1 for CLKS_PER_BIT cycles. Then:
  - if byte_cnt==FRAME_LEN-1: go to IDLE, busy=0, done=1 for one cycle, byte_cnt=0.
  - otherwise: byte_cnt+1, go to FETCH.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps.
  - It is reset to 0 on entry to START, DATA (each bit) and STOP.
  - Its width is the minimum needed to hold CLKS_PER_BIT-1.
- Inter-byte gap: 2 cycles (FETCH+LOAD), with tx held high during the gap. The frame line time is therefore FRAME_LEN*(10*CLKS_PER_BIT+2) cycles.
- Latency: the start edge leads to the tx falling edge 3 cycles later (IDLE->FETCH->LOAD->START).
- done and start in the same cycle: done occurs in IDLE, so the start is accepted and the next frame begins with no extra gap.
- rd_addr holds its last value when rd_en=0. The buffer must not be rewritten while busy=1; the buffer owner guarantees this and the block does not check it.
- tx is a registered output and must be glitch-free.
- byte_cnt never exceeds FRAME_LEN-1.

Test Plan:
- Reset behaviour: CLKS_PER_BIT=4, FRAME_LEN=3. Hold rst 3 cycles -> tx=1, busy=0, done=0, rd_en=0 throughout and after release.
- Single frame:
  - Stimulus: buffer holds 0xA5, 0x00, 0xFF; pulse start.
  - rd_en fires at addr 0, 1, 2, each 42 cycles apart.
  - tx shows 0,1,0,1,0,0,1,0,1,1 for byte 0, with each bit 4 cycles.
  - done pulses once, 126 cycles after the start edge.
  - busy=1 exactly for that window.
- Ignored start: pulse start again mid-byte-1 -> no extra rd_en, frame length unchanged, exactly one done.
- Back-to-back frames: assert start in the done cycle -> the second frame's first rd_en comes 1 cycle after done, and both frames decode correctly in a UART monitor.
- Reset mid-frame: assert rst during the DATA bit 3 of byte 1 -> tx=1 next cycle, busy=0, no done pulse. A new start then sends from addr 0.
- Default parameters (434, 517): monitor decodes a 517-byte random frame with 0 errors; done is asserted at cycle 517*4342.
